// File: rtl/fpga.sv
// fpga -- WIDTH-bit universal shift register.
//
// Each clock the register either holds, parallel-loads datain, shifts left
// (LSB filled from sin) or shifts right (MSB filled from sin). Load wins over
// both shifts; shl and shr together cancel to a hold. The next-state logic is
// an array of identical 4:1 bit slices; the register itself lives in the top
// so dataout comes straight from flops.
//
// Ports
//   clk     in  1      rising-edge clock
//   rst_n   in  1      async active-low reset, clears the register
//   datain  in  WIDTH  parallel load data
//   shl     in  1      shift left one place
//   shr     in  1      shift right one place
//   l       in  1      parallel load (highest priority)
//   sin     in  1      serial fill bit for either shift direction
//   dataout out WIDTH  register contents

// One bit slice: picks this bit's next value from its four candidates.
module fpga_slice (
  input  logic [1:0] sel,
  input  logic       q,     // current value of this bit (hold)
  input  logic       d,     // parallel load bit
  input  logic       nbr_l, // lower neighbour, or sin at bit 0 (shift left)
  input  logic       nbr_r, // upper neighbour, or sin at MSB (shift right)
  output logic       nxt
);
  always_comb begin
    nxt = q;
    unique case (sel)
      2'd0: nxt = q;
      2'd1: nxt = d;
      2'd2: nxt = nbr_l;
      2'd3: nxt = nbr_r;
      default: nxt = q;
    endcase
  end
endmodule

module fpga #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] datain,
  input  logic             shl,
  input  logic             shr,
  input  logic             l,
  input  logic             sin,
  output logic [WIDTH-1:0] dataout
);
  typedef enum logic [1:0] {
    M_HOLD = 2'd0,
    M_LOAD = 2'd1,
    M_SHL  = 2'd2,
    M_SHR  = 2'd3
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] nbr_l, nbr_r, nxt;

  // Load first; shl and shr asserted together fall through to hold.
  always_comb begin
    mode = M_HOLD;
    if (l)                mode = M_LOAD;
    else if (shl && !shr) mode = M_SHL;
    else if (shr && !shl) mode = M_SHR;
  end

  // Neighbour buses with sin already spliced in at the two boundary slices.
  assign nbr_l = {dataout[WIDTH-2:0], sin};
  assign nbr_r = {sin, dataout[WIDTH-1:1]};

  fpga_slice u_slice [WIDTH-1:0] (
    .sel   ({WIDTH{mode}}),
    .q     (dataout),
    .d     (datain),
    .nbr_l (nbr_l),
    .nbr_r (nbr_r),
    .nxt   (nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dataout <= '0;
    else        dataout <= nxt;
  end
endmodule

// File: tb/tb_fpga.sv
module tb_fpga;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] datain = '0;
  logic       shl = 1'b0, shr = 1'b0, l = 1'b0, sin = 1'b0;
  logic [7:0] dataout;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic [7:0] model = '0;

  fpga #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .datain(datain), .dataout(dataout),
    .shl(shl), .shr(shr), .l(l), .sin(sin)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on a byte, async clear on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            model = 8'h00;
    else if (l)            model = datain;
    else if (shr && !shl)  model = (model >> 1) | (sin ? 8'h80 : 8'h00);
    else if (shl && !shr)  model = (model << 1) | (sin ? 8'h01 : 8'h00);
  end

  // Continuous check of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dataout !== model) begin
        failures++;
        $display("FAIL model_cmp t=%0t dataout=%02h expected=%02h", $time, dataout, model);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] exp);
    checks++;
    if (dataout !== exp) begin
      failures++;
      $display("FAIL %s dataout=%02h expected=%02h", name, dataout, exp);
    end
  endtask

  task automatic ctl(input logic il, input logic ishl, input logic ishr,
                     input logic isin, input logic [7:0] d);
    l = il; shl = ishl; shr = ishr; sin = isin; datain = d;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 lit("reset_state", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Load then right shift with sin=1
    ctl(1, 0, 0, 0, 8'hAB); edges(1); lit("load_ab", 8'hAB);
    ctl(0, 0, 1, 1, 8'h00); edges(5); lit("shr5_sin1", 8'hFD);
    edges(3); lit("shr8_sin1_sat", 8'hFF);

    // Load then left shift with sin=1, then hold
    ctl(1, 0, 0, 0, 8'hB7); edges(1); lit("load_b7", 8'hB7);
    ctl(0, 1, 0, 1, 8'h00); edges(4); lit("shl4_sin1", 8'h7F);
    ctl(0, 0, 0, 0, 8'h00); edges(1); lit("idle_hold", 8'h7F);

    // Load priority over both shifts, then shl=shr hold
    ctl(1, 0, 0, 0, 8'h5A); edges(1); lit("load_5a", 8'h5A);
    ctl(1, 1, 1, 1, 8'h3C); edges(1); lit("load_prio", 8'h3C);
    ctl(0, 1, 1, 1, 8'hFF);
    for (int i = 0; i < 3; i++) begin edges(1); lit("conflict_hold", 8'h3C); end

    // Zero fill both directions
    ctl(1, 0, 0, 0, 8'hFF); edges(1);
    ctl(0, 0, 1, 0, 8'h00);
    edges(1); lit("shr_zero_1", 8'h7F);
    edges(1); lit("shr_zero_2", 8'h3F);
    edges(1); lit("shr_zero_3", 8'h1F);
    ctl(1, 0, 0, 0, 8'h81); edges(1);
    ctl(0, 1, 0, 0, 8'h00); edges(1); lit("shl_zero", 8'h02);

    // Alternating sin into left shifts: each edge inserts exactly one bit
    ctl(1, 0, 0, 0, 8'h00); edges(1);
    for (int i = 0; i < 4; i++) begin
      ctl(0, 1, 0, i[0], 8'h00); edges(1);
    end
    lit("shl_alt_sin", 8'h05);

    // Async reset mid shift sequence
    ctl(1, 0, 0, 0, 8'hAB); edges(1);
    ctl(0, 0, 1, 1, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 lit("async_clear", 8'h00);
    ctl(1, 1, 0, 1, 8'h55);
    edges(2); lit("reset_ignores_ctl", 8'h00);
    ctl(1, 0, 0, 0, 8'hC3);
    rst_n = 1'b1;
    edges(1); lit("post_release_load", 8'hC3);
    ctl(0, 0, 1, 0, 8'h00); edges(1); lit("post_release_shr", 8'h61);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpga.md
FPGA -- requirements
Module: fpga

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 8, SHALL set the register width; all values below assume WIDTH=8.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port datain SHALL be an input, WIDTH bits: parallel load data.
REQ-006 Port dataout SHALL be an output, WIDTH bits: current register contents, driven directly from flops.
REQ-007 Port shl SHALL be an input, 1 bit: shift left one place per clock.
REQ-008 Port shr SHALL be an input, 1 bit: shift right one place per clock.
REQ-009 Port l SHALL be an input, 1 bit: parallel load.
REQ-010 Port sin SHALL be an input, 1 bit: serial fill bit for both shift directions.

Function
REQ-011 The block SHALL be a WIDTH-bit universal shift register, updated only on the rising edge of clk while rst_n=1.
REQ-012 If l=1, the next value SHALL be datain, regardless of shl and shr.
REQ-013 If l=0, shr=1 and shl=0, the next value SHALL be {sin, dataout[WIDTH-1:1]} (MSB filled from sin).
REQ-014 If l=0, shl=1 and shr=0, the next value SHALL be {dataout[WIDTH-2:0], sin} (LSB filled from sin).
REQ-015 If l=0 and shl=shr (both 0 or both 1), the register SHALL hold its value.
REQ-016 Latency SHALL be one clock: a control change takes effect at the first rising edge after it.
REQ-017 dataout SHALL change only at clock edges or on reset assertion; it SHALL have no combinational path from the inputs.
REQ-018 sin SHALL be sampled at the same edge as the shift it feeds, so each shift inserts exactly one sin bit.
REQ-019 The next-state logic SHALL be built as WIDTH identical bit slices, each slice a 4:1 select (hold, load, left-neighbour, right-neighbour), with sin at the two boundary slices.
REQ-020 A shift SHALL have no saturation: after WIDTH or more consecutive shifts, the register SHALL hold all copies of sin.

Reset
REQ-021 rst_n=0 SHALL clear dataout to 0 immediately and asynchronously, independent of clk.
REQ-022 While rst_n=0, all control inputs SHALL be ignored.
REQ-023 After rst_n is released, the first update SHALL occur at the next rising clk edge.
REQ-024 Reset asserted in the middle of a shift sequence SHALL abort it; the register SHALL restart from 0.

Verification
REQ-025 Load then right shift: l=1, datain=10101011, one edge gives dataout=10101011; then shr=1, sin=1, five edges give 11111101; three more edges give 11111111.
REQ-026 Load then left shift: l=1, datain=10110111, one edge gives 10110111; then shl=1, sin=1, four edges give 01111111; then all controls 0, one edge still gives 01111111.
REQ-027 Priority and conflict: hold 0x5A; l=1, shl=1, shr=1, datain=0x3C gives 0x3C after one edge; l=0, shl=shr=1 holds 0x3C for three edges.
REQ-028 Zero fill: hold 0xFF; sin=0, shr=1 gives 0x7F, 0x3F, 0x1F over three edges; sin=0, shl=1 from 0x81 gives 0x02.
REQ-029 Asynchronous reset: with 0xAB loaded and shr active, pulling rst_n low between edges forces dataout=0x00 at once; it stays 0x00 through clock edges until release, after which the next edge resumes normal operation.
